// File: rtl/apb2apb_cdc_bridge.sv
// APB-to-APB bridge between two asynchronous clock domains.
// The master side (PCLK_PM) captures one request per PENABLE_PM rising edge and hands it
// across with a toggle handshake. The slave side (PCLK_SC) runs a full APB
// SETUP/ACCESS cycle with slot decode and an optional timeout. The response
// returns through a second toggle handshake.
// Ports:
//   PCLK_PM, PRESETN_PM                         master clock, async active-low reset
//   PADDR_PM/PWRITE_PM/PENABLE_PM/PWDATA_PM     master request
//   PRDATA_PM/PREADY_PM/PSLVERR_PM              master completion (PREADY_PM is a 1-cycle pulse)
//   PCLK_SC                                     slave clock
//   PSEL_SC/PADDR_SC/PWRITE_SC/PENABLE_SC/PWDATA_SC   slave request
//   PRDATA_SC/PREADY_SC/PSLVERR_SC              slave response
//   TIMEOUT_CNT_PM                              saturating count of timed-out transfers
// TPD is the output delay of the original simulation model. The registered outputs here carry no delay.
`timescale 1ns/1ps
module apb2apb_cdc_bridge #(
  parameter int NUM_SLOTS  = 16,
  parameter int SEL_LSB    = 24,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256,
  parameter int TPD        = 1
) (
  input  logic                  PCLK_PM,
  input  logic                  PRESETN_PM,
  input  logic                  PCLK_SC,
  input  logic [31:0]           PADDR_PM,
  input  logic                  PWRITE_PM,
  input  logic                  PENABLE_PM,
  input  logic [DATA_WIDTH-1:0] PWDATA_PM,
  output logic [DATA_WIDTH-1:0] PRDATA_PM,
  output logic                  PREADY_PM,
  output logic                  PSLVERR_PM,
  output logic [NUM_SLOTS-1:0]  PSEL_SC,
  output logic [31:0]           PADDR_SC,
  output logic                  PWRITE_SC,
  output logic                  PENABLE_SC,
  output logic [DATA_WIDTH-1:0] PWDATA_SC,
  input  logic [DATA_WIDTH-1:0] PRDATA_SC,
  input  logic                  PREADY_SC,
  input  logic                  PSLVERR_SC,
  output logic [7:0]            TIMEOUT_CNT_PM
);

  localparam int unsigned TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  localparam logic [0:0] PM_IDLE = 1'b0;
  localparam logic [0:0] PM_WAIT = 1'b1;

  localparam logic [1:0] SC_IDLE   = 2'd0;
  localparam logic [1:0] SC_SETUP  = 2'd1;
  localparam logic [1:0] SC_ACCESS = 2'd2;
  localparam logic [1:0] SC_DONE   = 2'd3;

  // Elaboration-time guard on parameter ranges
  if (NUM_SLOTS < 1 || NUM_SLOTS > 16 || SEL_LSB < 0 || SEL_LSB > 28 || TIMEOUT < 0 || TPD < 0 ||
      !(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32)) begin : g_param_check
    $error("apb2apb_cdc_bridge: parameter out of range");
  end

  // ---------------- master (PM) domain ----------------
  logic [0:0]            pm_state_q, pm_state_d;
  logic                  penable_q;
  logic                  req_tgl_q, req_tgl_d;
  logic [31:0]           hold_addr_q, hold_addr_d;
  logic [DATA_WIDTH-1:0] hold_wdata_q, hold_wdata_d;
  logic                  hold_write_q, hold_write_d;
  logic [1:0]            ack_sync_q;
  logic                  ack_seen_q;
  logic                  pready_q, pready_d;
  logic [DATA_WIDTH-1:0] prdata_pm_q, prdata_pm_d;
  logic                  pslverr_pm_q, pslverr_pm_d;
  logic [7:0]            to_cnt_pm_q, to_cnt_pm_d;
  logic                  ack_edge;

  // ---------------- slave (SC) domain ----------------
  logic [1:0]            rst_sync_q;
  logic                  rst_sc_n;
  logic [1:0]            sc_state_q, sc_state_d;
  logic [1:0]            req_sync_q;
  logic                  req_seen_q;
  logic                  req_edge;
  logic [NUM_SLOTS-1:0]  psel_q, psel_d;
  logic [31:0]           paddr_sc_q, paddr_sc_d;
  logic [DATA_WIDTH-1:0] pwdata_sc_q, pwdata_sc_d;
  logic                  pwrite_sc_q, pwrite_sc_d;
  logic                  penable_sc_q, penable_sc_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_to_q, rsp_to_d;
  logic                  ack_tgl_q, ack_tgl_d;
  logic [TO_W-1:0]       to_cnt_sc_q, to_cnt_sc_d;
  logic [3:0]            slot_idx;
  logic                  slot_ok;

  assign ack_edge = ack_sync_q[1] ^ ack_seen_q;

  // PM next state: capture on PENABLE_PM rise in IDLE, complete on returned ack
  always_comb begin
    pm_state_d   = pm_state_q;
    req_tgl_d    = req_tgl_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    hold_write_d = hold_write_q;
    pready_d     = 1'b0;
    prdata_pm_d  = prdata_pm_q;
    pslverr_pm_d = pslverr_pm_q;
    to_cnt_pm_d  = to_cnt_pm_q;
    case (pm_state_q)
      PM_IDLE: begin
        if (PENABLE_PM && !penable_q) begin
          hold_addr_d  = PADDR_PM;
          hold_wdata_d = PWDATA_PM;
          hold_write_d = PWRITE_PM;
          req_tgl_d    = ~req_tgl_q;
          pm_state_d   = PM_WAIT;
        end
      end
      PM_WAIT: begin
        // Response registers are SC-domain but static from before ack_tgl flips until the next request
        if (ack_edge) begin
          pready_d     = 1'b1;
          prdata_pm_d  = rsp_data_q;
          pslverr_pm_d = rsp_err_q;
          if (rsp_to_q && to_cnt_pm_q != 8'hFF) to_cnt_pm_d = to_cnt_pm_q + 8'd1;
          pm_state_d   = PM_IDLE;
        end
      end
      default: pm_state_d = PM_IDLE;
    endcase
  end

  // PM state and output registers
  always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
    if (!PRESETN_PM) begin
      pm_state_q   <= PM_IDLE;
      penable_q    <= 1'b0;
      req_tgl_q    <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_write_q <= 1'b0;
      ack_sync_q   <= 2'b00;
      ack_seen_q   <= 1'b0;
      pready_q     <= 1'b0;
      prdata_pm_q  <= '0;
      pslverr_pm_q <= 1'b0;
      to_cnt_pm_q  <= 8'd0;
    end else begin
      pm_state_q   <= pm_state_d;
      penable_q    <= PENABLE_PM;
      req_tgl_q    <= req_tgl_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      hold_write_q <= hold_write_d;
      ack_sync_q   <= {ack_sync_q[0], ack_tgl_q};
      ack_seen_q   <= ack_sync_q[1];
      pready_q     <= pready_d;
      prdata_pm_q  <= prdata_pm_d;
      pslverr_pm_q <= pslverr_pm_d;
      to_cnt_pm_q  <= to_cnt_pm_d;
    end
  end

  // SC reset: asserted with PRESETN_PM, released two PCLK_SC edges later
  always_ff @(posedge PCLK_SC or negedge PRESETN_PM) begin
    if (!PRESETN_PM) rst_sync_q <= 2'b00;
    else             rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_sc_n = rst_sync_q[1];

  assign req_edge = req_sync_q[1] ^ req_seen_q;
  assign slot_idx = hold_addr_q[SEL_LSB +: 4];
  assign slot_ok  = ({1'b0, slot_idx} < 5'(NUM_SLOTS));

  // SC next state: APB SETUP/ACCESS sequencing, decode, timeout
  always_comb begin
    sc_state_d   = sc_state_q;
    psel_d       = psel_q;
    paddr_sc_d   = paddr_sc_q;
    pwdata_sc_d  = pwdata_sc_q;
    pwrite_sc_d  = pwrite_sc_q;
    penable_sc_d = penable_sc_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    rsp_to_d     = rsp_to_q;
    ack_tgl_d    = ack_tgl_q;
    to_cnt_sc_d  = to_cnt_sc_q;
    case (sc_state_q)
      SC_IDLE: begin
        if (req_edge) begin
          if (slot_ok) begin
            for (int i = 0; i < NUM_SLOTS; i++) psel_d[i] = (slot_idx == 4'(i));
            paddr_sc_d   = hold_addr_q;
            pwdata_sc_d  = hold_wdata_q;
            pwrite_sc_d  = hold_write_q;
            penable_sc_d = 1'b0;
            sc_state_d   = SC_SETUP;
          end else begin
            // Undecoded slot: answer with an error without touching the bus
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            rsp_to_d   = 1'b0;
            sc_state_d = SC_DONE;
          end
        end
      end
      SC_SETUP: begin
        penable_sc_d = 1'b1;
        to_cnt_sc_d  = '0;
        sc_state_d   = SC_ACCESS;
      end
      SC_ACCESS: begin
        if (PREADY_SC || (TIMEOUT > 0 && to_cnt_sc_q == TO_W'(TO_LAST))) begin
          rsp_data_d   = PREADY_SC ? PRDATA_SC : '0;
          rsp_err_d    = PREADY_SC ? PSLVERR_SC : 1'b1;
          rsp_to_d     = ~PREADY_SC;
          psel_d       = '0;
          penable_sc_d = 1'b0;
          paddr_sc_d   = '0;
          pwdata_sc_d  = '0;
          pwrite_sc_d  = 1'b0;
          sc_state_d   = SC_DONE;
        end else begin
          to_cnt_sc_d = to_cnt_sc_q + TO_W'(1);
        end
      end
      SC_DONE: begin
        ack_tgl_d  = ~ack_tgl_q;
        sc_state_d = SC_IDLE;
      end
      default: sc_state_d = SC_IDLE;
    endcase
  end

  // SC state and output registers
  always_ff @(posedge PCLK_SC or negedge rst_sc_n) begin
    if (!rst_sc_n) begin
      sc_state_q   <= SC_IDLE;
      req_sync_q   <= 2'b00;
      req_seen_q   <= 1'b0;
      psel_q       <= '0;
      paddr_sc_q   <= '0;
      pwdata_sc_q  <= '0;
      pwrite_sc_q  <= 1'b0;
      penable_sc_q <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      rsp_to_q     <= 1'b0;
      ack_tgl_q    <= 1'b0;
      to_cnt_sc_q  <= '0;
    end else begin
      sc_state_q   <= sc_state_d;
      req_sync_q   <= {req_sync_q[0], req_tgl_q};
      req_seen_q   <= req_sync_q[1];
      psel_q       <= psel_d;
      paddr_sc_q   <= paddr_sc_d;
      pwdata_sc_q  <= pwdata_sc_d;
      pwrite_sc_q  <= pwrite_sc_d;
      penable_sc_q <= penable_sc_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      rsp_to_q     <= rsp_to_d;
      ack_tgl_q    <= ack_tgl_d;
      to_cnt_sc_q  <= to_cnt_sc_d;
    end
  end

  assign PREADY_PM      = pready_q;
  assign PRDATA_PM      = prdata_pm_q;
  assign PSLVERR_PM     = pslverr_pm_q;
  assign TIMEOUT_CNT_PM = to_cnt_pm_q;
  assign PSEL_SC        = psel_q;
  assign PADDR_SC       = paddr_sc_q;
  assign PWDATA_SC      = pwdata_sc_q;
  assign PWRITE_SC      = pwrite_sc_q;
  assign PENABLE_SC     = penable_sc_q;

endmodule
